// File: rtl/alu_seq_if.sv
// alu_iface: operand/opcode bundle between a sequencer (master) and a combinational ALU (slave).
//   a, b, op : driven by master, 4 bits each
//   out      : ALU result, driven by slave, 4 bits
interface alu_iface;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic [3:0] out;

  modport master (output a, output b, output op, input out);
  modport slave  (input a, input b, input op, output out);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: command-driven ALU sequencer with a 4-bit accumulator, a DEPTH-entry
// command FIFO and a single-entry valid/ready response slot.
//   clk, rst      : clock, asynchronous active-high reset
//   aif           : ALU master port (a = accumulator, b/op from head command)
//   cmd_*         : command channel {load, op, b}, valid/ready
//   rsp_*         : response channel, accumulator value after each command
//   count         : FIFO occupancy 0..DEPTH
module alu_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_iface.master        aif,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_load,
  input  logic [3:0]      cmd_op,
  input  logic [3:0]      cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [3:0]      rsp_data,
  output logic [2:0]      count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DAT_W = 4;

  localparam logic [0:0] RSP_EMPTY = 1'b0;
  localparam logic [0:0] RSP_FULL  = 1'b1;

  typedef struct packed {
    logic             load;
    logic [DAT_W-1:0] op;
    logic [DAT_W-1:0] b;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DAT_W-1:0] acc_q, acc_d;
  logic [DAT_W-1:0] rsp_data_q, rsp_data_d;
  logic [0:0]       rsp_state_q, rsp_state_d;
  logic             cmd_ready_q, cmd_ready_d;

  cmd_t             head_c;
  logic             fifo_empty_c;
  logic             push_c;
  logic             issue_c;
  logic [DAT_W-1:0] result_c;

  // Handshake decode; cmd_ready_q already encodes "not full"
  always_comb begin
    head_c       = mem_q[rd_ptr_q];
    fifo_empty_c = (count_q == '0);
    push_c       = cmd_valid && cmd_ready_q;
    issue_c      = !fifo_empty_c && ((rsp_state_q == RSP_EMPTY) || rsp_ready);
    result_c     = head_c.load ? head_c.b : aif.out;
  end

  // ALU drive: head command when one is queued, zeros otherwise
  always_comb begin
    aif.a  = acc_q;
    aif.b  = '0;
    aif.op = '0;
    if (!fifo_empty_c) begin
      aif.b  = head_c.b;
      aif.op = head_c.op;
    end
  end

  // Next-state: pointers, occupancy, accumulator and response slot
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    acc_d       = acc_q;
    rsp_data_d  = rsp_data_q;
    rsp_state_d = rsp_state_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (issue_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      acc_d      = result_c;
      rsp_data_d = result_c;
    end

    case ({push_c, issue_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (rsp_state_q)
      RSP_EMPTY: if (issue_c) rsp_state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !issue_c) rsp_state_d = RSP_EMPTY;
      default:   rsp_state_d = RSP_EMPTY;
    endcase

    // Registered so rsp_ready never reaches cmd_ready combinationally
    cmd_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      rsp_data_q  <= '0;
      rsp_state_q <= RSP_EMPTY;
      cmd_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_state_q <= rsp_state_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Command storage; validity is tracked by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= cmd_t'{load: cmd_load, op: cmd_op, b: cmd_b};
  end

  assign cmd_ready = cmd_ready_q;
  assign count     = count_q;
  assign rsp_valid = rsp_state_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized bench for alu_seq with an attached
// behavioural ALU and an in-order reference queue of expected accumulator values.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_op;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] count;

  alu_iface aif ();

  alu_seq #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .aif       (aif),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .count     (count)
  );

  // ALU behaviour in plain mod-16 arithmetic
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    case (op[1:0])
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return 4'((ai - bi + 16) % 16);
      default: return 4'((ai + bi) % 16);
    endcase
  endfunction

  assign aif.out = alu_f(aif.a, aif.b, aif.op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [3:0] acc_m;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [3:0] want [5];
  logic       done;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: score handshakes seen before the edge, then step to edge+1
  task automatic cycle();
    logic acc_fire;
    logic rsp_fire;
    acc_fire = cmd_valid && cmd_ready;
    rsp_fire = rsp_valid && rsp_ready;
    if (rsp_fire) begin
      got_q.push_back(rsp_data);
      if (exp_q.size() == 0) chk("rsp_unexpected", 8'(1), 8'(0));
      else                   chk("rsp_data", 8'(rsp_data), 8'(exp_q.pop_front()));
    end
    if (acc_fire) begin
      acc_m = cmd_load ? cmd_b : alu_f(acc_m, cmd_b, cmd_op);
      exp_q.push_back(acc_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      cycle();
    end
    chk("drain_done", 8'(exp_q.size() == 0 && !rsp_valid), 8'(1));
  endtask

  task automatic send(input logic ld, input logic [3:0] op, input logic [3:0] b);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_b     = b;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_b = '0;
    rsp_ready = 1'b0; acc_m = '0;
    #3;
    chk("rst_rsp_valid", 8'(rsp_valid), 8'(0));
    chk("rst_rsp_data",  8'(rsp_data),  8'(0));
    chk("rst_count",     8'(count),     8'(0));
    chk("rst_cmd_ready", 8'(cmd_ready), 8'(1));
    chk("rst_aif_a",     8'(aif.a),     8'(0));
    chk("rst_aif_b",     8'(aif.b),     8'(0));
    chk("rst_aif_op",    8'(aif.op),    8'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Load/add with first-response latency
    got_q.delete();
    rsp_ready = 1'b1;
    send(1'b1, 4'd0, 4'd5);
    chk("ld_lat_valid0", 8'(rsp_valid), 8'(0));
    chk("ld_lat_count1", 8'(count),     8'(1));
    send(1'b0, 4'd3, 4'd3);
    chk("ld_lat_valid1", 8'(rsp_valid), 8'(1));
    chk("ld_lat_data5",  8'(rsp_data),  8'(5));
    cmd_valid = 1'b0;
    cycle();
    chk("ld_add_data8",  8'(rsp_data),  8'(8));
    drain();
    chk("ld_add_n", 8'(got_q.size()), 8'(2));

    // Wrap arithmetic chain
    got_q.delete();
    send(1'b1, 4'd0, 4'd9);
    send(1'b0, 4'd3, 4'd9);
    send(1'b0, 4'd2, 4'd5);
    send(1'b0, 4'd1, 4'd6);
    send(1'b0, 4'd0, 4'd1);
    drain();
    want = '{4'd9, 4'd2, 4'd13, 4'd4, 4'd5};
    chk("arith_n", 8'(got_q.size()), 8'(5));
    if (got_q.size() == 5)
      for (int k = 0; k < 5; k++) chk("arith_seq", 8'(got_q[k]), 8'(want[k]));

    // Backpressure: six offers, one into the slot and four queued
    got_q.delete();
    rsp_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b1, 4'($urandom), 4'(i));
    chk("bp_count4",    8'(count),     8'(4));
    chk("bp_ready0",    8'(cmd_ready), 8'(0));
    chk("bp_valid",     8'(rsp_valid), 8'(1));
    chk("bp_data1",     8'(rsp_data),  8'(1));
    cmd_valid = 1'b0;
    cycle();
    cycle();
    chk("bp_hold_data", 8'(rsp_data),  8'(1));
    chk("bp_hold_cnt",  8'(count),     8'(4));
    // Full boundary: offer while full with a pop in the same cycle
    rsp_ready = 1'b1;
    send(1'b1, 4'd0, 4'd7);
    chk("full_count3",  8'(count),     8'(3));
    chk("full_ready1",  8'(cmd_ready), 8'(1));
    chk("full_data2",   8'(rsp_data),  8'(2));
    drain();
    chk("bp_n", 8'(got_q.size()), 8'(5));
    if (got_q.size() == 5)
      for (int k = 0; k < 5; k++) chk("bp_seq", 8'(got_q[k]), 8'(k + 1));

    // Pointer wrap: ten loads under random backpressure
    got_q.delete();
    for (int i = 1; i <= 10; i++) begin
      cmd_valid = 1'b1;
      cmd_load  = 1'b1;
      cmd_b     = 4'(i);
      cmd_op    = 4'($urandom);
      done      = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        done      = cmd_ready;
        cycle();
      end
      chk("wrap_accept", 8'(done), 8'(1));
    end
    drain();
    chk("wrap_n", 8'(got_q.size()), 8'(10));
    if (got_q.size() == 10)
      for (int k = 0; k < 10; k++) chk("wrap_seq", 8'(got_q[k]), 8'(k + 1));

    // Random traffic against the reference queue
    for (int t = 0; t < 300; t++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_load  = ($urandom_range(0, 3) == 0);
      cmd_op    = 4'($urandom);
      cmd_b     = 4'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    // Reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b1, 4'd0, 4'(i + 10));
    chk("mid_pre_count", 8'(count),     8'(3));
    chk("mid_pre_valid", 8'(rsp_valid), 8'(1));
    cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 8'(rsp_valid), 8'(0));
    chk("mid_rst_count", 8'(count),     8'(0));
    chk("mid_rst_acc",   8'(aif.a),     8'(0));
    chk("mid_rst_ready", 8'(cmd_ready), 8'(1));
    exp_q.delete();
    acc_m = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(1'b0, 4'd3, 4'd7);
    cmd_valid = 1'b0;
    cycle();
    chk("mid_after_valid", 8'(rsp_valid), 8'(1));
    chk("mid_after_data7", 8'(rsp_data),  8'(7));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
